ram_ws_ctrl: RTL and testbench
==============================

Name: ram_ws_ctrl

Overview:
- Parametrised single-port synchronous RAM with a programmable wait-state count and an mv (memory valid) completion handshake.
- Successor to the fixed 256x8 RAM: width, depth and access latency are generic.
- Adds a dedicated preload port, so testbenches and boot logic can initialise contents through RTL instead of hierarchical pokes.
- Sits between the CPU/control unit and storage. The requester raises enable and waits for mv.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of implemented words (<= 2**ADDR_W)
- WAIT_CYCLES, 2, wait states between request acceptance and completion (0..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  transaction request
- rw  in  1  1 = write, 0 = read (sampled with enable)
- address  in  ADDR_W  word address (sampled with enable)
- DaIn  in  DATA_W  write data (sampled with enable)
- DaOut  out  DATA_W  read data, registered
- mv  out  1  one-cycle completion pulse
- busy  out  1  transaction in progress (WAIT or DONE)
- err  out  1  out-of-range flag, valid with mv
- ld_en  in  1  preload write strobe
- ld_addr  in  ADDR_W  preload address
- ld_data  in  DATA_W  preload data

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset); polarity and synchronicity are fixed.
- Reset values: DaOut=0, mv=0, busy=0, err=0, FSM=IDLE, wait counter=0. Memory contents are NOT cleared by reset.
- FSM states: IDLE, WAIT, DONE.
- IDLE, ld_en=1: write ld_data to mem[ld_addr] if ld_addr<DEPTH. Request acceptance is suppressed that cycle; ld_en has priority over enable.
- IDLE, enable=1 and ld_en=0: latch rw, address and DaIn into internal registers; counter<=WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, else DONE.
- WAIT: decrement counter; go to DONE when the counter reaches 1 (i.e. WAIT_CYCLES cycles are spent in WAIT). Inputs are ignored; enable, address, DaIn and rw changes have no effect.
- DONE: perform the access using the latched values.
  - Write: mem[addr]<=data.
  - Read: DaOut<=mem[addr].
  - mv=1 for exactly this cycle, with err driven alongside it. Next state is IDLE.
- mv timing: acceptance edge at cycle 0, mv high during cycle WAIT_CYCLES+1. DaOut is valid in the same cycle as mv and holds until the next completed read.
- Back-to-back: holding enable high yields a new acceptance on the IDLE cycle following DONE. Throughput is one transaction per WAIT_CYCLES+2 cycles.
- ld_en outside IDLE: ignored (no write).
- Out of range (latched address >= DEPTH):
  - write is dropped;
  - read leaves DaOut=0;
  - mv still pulses, with err=1 for that cycle.
- In-range access: err=0.
- Read-after-write: a read accepted after a write's DONE returns the new data.
- Reset mid-transaction: any state returns to IDLE; a pending write is aborted (memory unchanged) and no mv is produced.
- Address wrap: none. Addresses are not modulo DEPTH.
- busy=1 in WAIT and DONE, 0 in IDLE.

Test Plan:
- Reset then write/read (DATA_W=8, WAIT_CYCLES=2):
  - Write 8'hA5 to address 3 -> mv high 3 cycles after acceptance, err=0.
  - Read address 3 -> DaOut=8'hA5 in the mv cycle.
- Preload:
  - ld_en with addresses 0..3 and data 8'h11, 22, 33, 44, then sequential reads -> DaOut 11, 22, 33, 44, each with one mv pulse.
  - ld_en asserted while busy -> location unchanged.
- Input hold: change address/DaIn during WAIT (write 8'h0F to addr 5, alter inputs to addr 6 / 8'hFF) -> mem[5]=0F and mem[6] unchanged.
- Boundaries with DEPTH=200:
  - Write to address 200 -> mv=1, err=1, no memory change.
  - Read address 250 -> DaOut=0, err=1.
  - Address 199 -> normal access.
- Reset mid-write: assert reset during WAIT of a write of 8'h77 to addr 9 -> no mv; subsequent read of addr 9 returns the prior value.
- WAIT_CYCLES=0, enable held high: mv every 2nd cycle; back-to-back read/write/read of addr 1 returns old then new data.

Source files
------------

// File: rtl/ram_ws_ctrl.sv
// Single-port synchronous RAM. Each request spends WAIT_CYCLES cycles in WAIT and then completes with a one-cycle mv pulse.
// A preload port writes directly into the array, but only while the controller is idle.
module ram_ws_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] DaIn,
    output logic [DATA_W-1:0] DaOut,
    output logic              mv,
    output logic              busy,
    output logic              err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                accept;
    logic                fire;
    logic                pre_wr;
    logic                acc_rw;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_data;
    logic                acc_ok;
    logic                ld_ok;
    logic [IDX_W-1:0]    acc_idx;
    logic [IDX_W-1:0]    ld_idx;

    logic [DATA_W-1:0]   mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fire      = 1'b0;
        pre_wr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (ld_en) begin
                    pre_wr = 1'b1;
                end else if (enable) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_DONE;
                        fire      = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = S_DONE;
                    fire      = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The access commits on the edge into DONE, so DaOut, mv and err all become
    // visible in the DONE cycle. With zero wait states the live request feeds the access.
    always_comb begin
        acc_rw   = (state == S_IDLE) ? rw      : rw_q;
        acc_addr = (state == S_IDLE) ? address : addr_q;
        acc_data = (state == S_IDLE) ? DaIn    : data_q;
        acc_ok   = in_range(acc_addr);
        acc_idx  = acc_addr[IDX_W-1:0];
        ld_ok    = in_range(ld_addr);
        ld_idx   = ld_addr[IDX_W-1:0];
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rw_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            DaOut  <= '0;
            mv     <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_nxt;
            mv    <= fire;
            err   <= fire && !acc_ok;
            if (accept) begin
                rw_q   <= rw;
                addr_q <= address;
                data_q <= DaIn;
                cnt    <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (fire && !acc_rw) begin
                DaOut <= acc_ok ? mem[acc_idx] : '0;
            end
        end
    end

    // Storage is deliberately not cleared by reset; reset only blocks writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (pre_wr && ld_ok) begin
                mem[ld_idx] <= ld_data;
            end else if (fire && acc_rw && acc_ok) begin
                mem[acc_idx] <= acc_data;
            end
        end
    end

endmodule

// File: tb/tb_ram_ws_ctrl.sv
// Directed bench: one instance with DEPTH=200 and two wait states, a second with zero wait states.
module tb_ram_ws_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, rw, mv, busy, err, ld_en;
    logic [7:0] address, din, dout, ld_addr, ld_data;

    logic       enable_b, rw_b, mv_b, busy_b, err_b, ld_en_b;
    logic [7:0] address_b, din_b, dout_b, ld_addr_b, ld_data_b;

    int checks = 0;
    int errors = 0;

    ram_ws_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .enable(enable), .rw(rw), .address(address),
        .DaIn(din), .DaOut(dout), .mv(mv), .busy(busy), .err(err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    ram_ws_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .enable(enable_b), .rw(rw_b), .address(address_b),
        .DaIn(din_b), .DaOut(dout_b), .mv(mv_b), .busy(busy_b), .err(err_b),
        .ld_en(ld_en_b), .ld_addr(ld_addr_b), .ld_data(ld_data_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on u0 and wait (bounded) for mv; lat counts samples from acceptance to mv.
    task automatic xact(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input bit alter, input bit ld_hold,
                        output logic [7:0] dat, output logic e, output int lat);
        rw      = w;
        address = a;
        din     = d;
        enable  = 1'b1;
        tick();
        lat    = 1;
        enable = 1'b0;
        if (alter) begin
            address = a + 8'd1;
            din     = 8'hFF;
            rw      = ~w;
        end
        if (ld_hold) ld_en = 1'b1;
        while (!mv && lat < 20) begin
            tick();
            lat++;
        end
        dat = dout;
        e   = err;
        tick();
        ld_en = 1'b0;
        chk("mv_single_pulse", mv, 1'b0);
    endtask

    task automatic op(input string tag, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_e, input bit alter, input bit ld_hold);
        logic [7:0] dat;
        logic       e;
        int         lat;
        xact(w, a, d, alter, ld_hold, dat, e, lat);
        if (!w) chk({tag, "_dat"}, dat, exp_d);
        chk({tag, "_err"}, e, exp_e);
        chk({tag, "_lat"}, lat, 3);
    endtask

    initial begin
        logic [7:0] pl_a [6];
        logic [7:0] pl_d [6];
        logic       any_mv;
        pl_a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd6, 8'd9};
        pl_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h99};

        reset = 1'b1; enable = 1'b0; rw = 1'b0; address = '0; din = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        enable_b = 1'b0; rw_b = 1'b0; address_b = '0; din_b = '0;
        ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;
        tick();
        tick();
        chk("rst_dout", dout, 8'h00);
        chk("rst_mv", mv, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_b_dout", dout_b, 8'h00);
        chk("rst_b_busy", busy_b, 1'b0);
        reset = 1'b0;
        tick();

        op("wr_a5", 1'b1, 8'd3, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0);
        op("rd_a5", 1'b0, 8'd3, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ld_en = 1'b1; ld_addr = pl_a[i]; ld_data = pl_d[i];
            tick();
        end
        ld_en = 1'b0;
        op("rd_pl0", 1'b0, 8'd0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0);
        op("rd_pl1", 1'b0, 8'd1, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0);
        op("rd_pl2", 1'b0, 8'd2, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0);
        op("rd_pl3", 1'b0, 8'd3, 8'h00, 8'h44, 1'b0, 1'b0, 1'b0);

        // ld_en wins over enable in IDLE: no request accepted, preload lands.
        ld_en = 1'b1; ld_addr = 8'd7; ld_data = 8'h5A;
        enable = 1'b1; rw = 1'b0; address = 8'd3;
        tick();
        chk("ld_prio_busy", busy, 1'b0);
        ld_en = 1'b0; enable = 1'b0;
        tick();
        op("rd_ld_prio", 1'b0, 8'd7, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0);

        ld_addr = 8'd2; ld_data = 8'hEE;
        op("rd_ld_busy", 1'b0, 8'd0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b1);
        op("rd_after_ld_busy", 1'b0, 8'd2, 8'h00, 8'h33, 1'b0, 1'b0, 1'b0);

        op("wr_hold", 1'b1, 8'd5, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b0);
        op("rd_hold5", 1'b0, 8'd5, 8'h00, 8'h0F, 1'b0, 1'b0, 1'b0);
        op("rd_hold6", 1'b0, 8'd6, 8'h00, 8'h66, 1'b0, 1'b0, 1'b0);

        op("wr_oor200", 1'b1, 8'd200, 8'h5C, 8'h00, 1'b1, 1'b0, 1'b0);
        op("rd_oor250", 1'b0, 8'd250, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        op("wr_199", 1'b1, 8'd199, 8'hC7, 8'h00, 1'b0, 1'b0, 1'b0);
        op("rd_199", 1'b0, 8'd199, 8'h00, 8'hC7, 1'b0, 1'b0, 1'b0);
        op("rd_0_after_oor", 1'b0, 8'd0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0);

        rw = 1'b1; address = 8'd9; din = 8'h77; enable = 1'b1;
        tick();
        enable = 1'b0;
        chk("rst_mid_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy_after", busy, 1'b0);
        any_mv = mv;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_mv = any_mv | mv;
        end
        chk("rst_mid_no_mv", any_mv, 1'b0);
        op("rd_9_after_abort", 1'b0, 8'd9, 8'h00, 8'h99, 1'b0, 1'b0, 1'b0);

        ld_en_b = 1'b1; ld_addr_b = 8'd1; ld_data_b = 8'hAB;
        tick();
        ld_en_b = 1'b0;
        enable_b = 1'b1; rw_b = 1'b0; address_b = 8'd1;
        tick();
        chk("w0_rd1_mv", mv_b, 1'b1);
        chk("w0_rd1_dat", dout_b, 8'hAB);
        chk("w0_rd1_busy", busy_b, 1'b1);
        rw_b = 1'b1; din_b = 8'hCD;
        tick();
        chk("w0_gap1_mv", mv_b, 1'b0);
        chk("w0_gap1_busy", busy_b, 1'b0);
        tick();
        chk("w0_wr_mv", mv_b, 1'b1);
        chk("w0_wr_err", err_b, 1'b0);
        rw_b = 1'b0;
        tick();
        chk("w0_gap2_mv", mv_b, 1'b0);
        tick();
        chk("w0_rd2_mv", mv_b, 1'b1);
        chk("w0_rd2_dat", dout_b, 8'hCD);
        enable_b = 1'b0;
        tick();
        chk("w0_end_mv", mv_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
